divisor_restoring: RTL and testbench

Sequential unsigned integer divider using the restoring algorithm, one quotient bit per clock cycle. A single-cycle `start` pulse launches a division of `A_in` by `B_in`. `Q` and `R` are presented when `done` rises. It is a standalone arithmetic datapath block for a control FSM or a test sequencer that issues one division at a time.

---
 rtl/divisor_restoring.sv | 112 +++++++++++
 tb/tb_divisor_restoring.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/divisor_restoring.sv
// Sequential unsigned restoring divider: one quotient bit per clock, result
// held in Q/R with a done level until the next accepted start or reset.
module divisor_restoring #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_done;

  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic [WIDTH:0]   w_p_sh;
  logic [WIDTH:0]   w_t;
  logic [WIDTH:0]   w_p_nxt;
  logic [WIDTH-1:0] w_s_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start)  w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_DONE;
      ST_DONE: if (start)  w_next = ST_RUN;
      default:             w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_last = 1'b0;
    unique case (r_state)
      ST_IDLE: w_load = start;
      ST_RUN: begin
        w_step = 1'b1;
        w_last = (r_cnt == CW'(WIDTH - 1));
      end
      ST_DONE: w_load = start;
      default: ;
    endcase
  end

  // A negative trial difference (MSB set) restores the shifted remainder.
  always_comb begin
    w_p_sh  = {r_p[WIDTH-1:0], r_s[WIDTH-1]};
    w_t     = w_p_sh - {1'b0, r_d};
    w_p_nxt = w_t[WIDTH] ? w_p_sh : w_t;
    w_s_nxt = {r_s[WIDTH-2:0], ~w_t[WIDTH]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p    <= '0;
      r_s    <= '0;
      r_d    <= '0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_done <= 1'b0;
    end else if (w_load) begin
      r_p    <= '0;
      r_s    <= A_in;
      r_d    <= B_in;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (w_step) begin
      r_p   <= w_p_nxt;
      r_s   <= w_s_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_q    <= w_s_nxt;
        r_r    <= w_p_nxt[WIDTH-1:0];
        r_done <= 1'b1;
      end
    end
  end

  assign Q    = r_q;
  assign R    = r_r;
  assign done = r_done;

endmodule

// File: tb/tb_divisor_restoring.sv
// Randomized self-checking bench for divisor_restoring against an arithmetic
// reference (integer / and %, all-ones quotient for a zero divisor).
module tb_divisor_restoring;

  localparam int unsigned WIDTH = 7;
  localparam int          MASK  = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;
  int prev_q   = 0;
  int prev_r   = 0;

  divisor_restoring #(.WIDTH(WIDTH)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A_in (A_in),
    .B_in (B_in),
    .Q    (Q),
    .R    (R),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input int a, input int b, output int q, output int r);
    if (b == 0) begin
      q = MASK;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // One division issued at the next falling edge; optionally pulses a
  // foreign start during RUN that must be ignored.
  task automatic do_div(input int a, input int b, input bit ign);
    int eq, er, cyc;
    ref_div(a, b, eq, er);
    @(negedge clk);
    A_in  = WIDTH'(a);
    B_in  = WIDTH'(b);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_fall", int'(done), 0);
    chk("q_hold", int'(Q), prev_q);
    chk("r_hold", int'(R), prev_r);
    cyc = 0;
    while (!done && cyc < 3 * WIDTH) begin
      if (cyc == 1) begin
        A_in = WIDTH'($urandom);
        B_in = WIDTH'($urandom);
      end
      if (ign && cyc == 2) begin
        start = 1'b1;
        A_in  = WIDTH'(10);
        B_in  = WIDTH'(3);
      end else if (ign && cyc == 3) begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    chk("latency", cyc, WIDTH);
    chk("quot", int'(Q), eq);
    chk("rem", int'(R), er);
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    int a, b;
    rst   = 1'b0;
    start = 1'b0;
    A_in  = '0;
    B_in  = '0;

    repeat (4) @(posedge clk);
    #1;
    chk("rst_q", int'(Q), 0);
    chk("rst_r", int'(R), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);

    do_div(50, 7, 1'b0);
    do_div(35, 5, 1'b0);
    do_div(63, 8, 1'b0);
    do_div(100, 15, 1'b0);

    do_div(127, 1, 1'b0);
    do_div(3, 9, 1'b0);
    do_div(0, 5, 1'b0);
    do_div(127, 127, 1'b0);

    do_div(5, 0, 1'b0);

    do_div(100, 15, 1'b1);

    // Reset asserted three iterations into 50/7.
    @(negedge clk);
    A_in  = WIDTH'(50);
    B_in  = WIDTH'(7);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_q", int'(Q), 0);
    chk("mid_rst_r", int'(R), 0);
    chk("mid_rst_done", int'(done), 0);
    repeat (WIDTH) @(posedge clk);
    #1;
    chk("mid_rst_done_hold", int'(done), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_done", int'(done), 0);
    prev_q = 0;
    prev_r = 0;
    do_div(20, 6, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, MASK));
      b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, MASK));
      do_div(a, b, ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
